imem_boot_loader: RTL

//  Boot-time controller for instruction_mem: drives its write port (we/waddr/wdata).

---
 rtl/imem_boot_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: packs a little-endian byte stream into 32-bit words and writes them to instruction memory from word 0.
// Latency: one word costs 4 byte transfers plus 1 write cycle; done pulses the cycle after the last write.
// Backpressure: byte_ready is high only in RECV; byte_valid low simply stalls, and there is no timeout.
module imem_boot_loader #(
   parameter int DEPTH = 64,
   parameter int LEN_W = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] len_words,
   input  logic             abort,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             we,
   output logic [31:0]      waddr,
   output logic [31:0]      wdata,
   output logic             cpu_hold,
   output logic             busy,
   output logic             done,
   output logic             error
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RECV  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] word_idx_q, word_idx_d;
   logic [1:0]       byte_idx_q, byte_idx_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      waddr_q, waddr_d;
   logic             error_q, error_d;

   logic len_ok;
   logic xfer;
   logic last_word;

   // A load length is legal when it covers at least one word and fits the memory.
   assign len_ok    = (len_words != '0) && (len_words <= LEN_W'(DEPTH));
   assign xfer      = byte_valid && byte_ready;
   assign last_word = (word_idx_q == (len_q - LEN_W'(1)));

   // Next-state logic: start handling, byte packing, word sequencing and abort.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      wdata_d    = wdata_q;
      waddr_d    = waddr_q;
      error_d    = error_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len_ok) begin
                  state_d    = S_RECV;
                  len_d      = len_words;
                  word_idx_d = '0;
                  byte_idx_d = '0;
                  error_d    = 1'b0;
               end else begin
                  error_d    = 1'b1;
               end
            end
         end
         S_RECV: begin
            if (abort) begin
               // Partial word and any byte offered this cycle are discarded.
               state_d = S_IDLE;
            end else if (xfer) begin
               wdata_d[8*byte_idx_q +: 8] = byte_data;
               byte_idx_d                 = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  state_d = S_WRITE;
                  waddr_d = 32'(word_idx_q) << 2;
               end
            end
         end
         S_WRITE: begin
            // The write in this cycle always completes; abort only stops what follows.
            if (abort) begin
               state_d = S_IDLE;
            end else if (last_word) begin
               state_d = S_DONE;
            end else begin
               word_idx_d = word_idx_q + LEN_W'(1);
               state_d    = S_RECV;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset cancels any load in flight at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         wdata_q    <= '0;
         waddr_q    <= '0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         wdata_q    <= wdata_d;
         waddr_q    <= waddr_d;
         error_q    <= error_d;
      end
   end

   // Control outputs are Moore decodes of the state register.
   assign byte_ready = (state_q == S_RECV);
   assign we         = (state_q == S_WRITE);
   assign busy       = (state_q == S_RECV) || (state_q == S_WRITE);
   assign cpu_hold   = busy;
   assign done       = (state_q == S_DONE);
   assign error      = error_q;
   assign waddr      = waddr_q;
   assign wdata      = wdata_q;

endmodule
